// File: rtl/neuron_o_feeder_if.sv
// Bus between the output-neuron feeder and its surroundings: the activation
// stream in, the held activations and neuron result, and the result stream out.
interface neuron_o_feeder_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic signed [WIDTH-1:0] a_1;
  logic signed [WIDTH-1:0] a_2;
  logic signed [WIDTH-1:0] y_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic [CNT_W-1:0]        res_cnt;
  logic                    busy;

  // Feeder side.
  modport slave (
    input  in_valid, in_data, y_in, out_ready,
    output in_ready, a_1, a_2, out_valid, out_data, res_cnt, busy
  );

  // Environment side: upstream source, neuron and downstream sink.
  modport master (
    output in_valid, in_data, y_in, out_ready,
    input  in_ready, a_1, a_2, out_valid, out_data, res_cnt, busy
  );
endinterface

// File: rtl/neuron_o_feeder.sv
// Output-neuron feeder: gathers an activation pair, holds it on a_1/a_2 for
// the combinational neuron, waits SETTLE cycles, then registers and offers y.
//
// state | meaning
// S_A1  | waiting for the first activation of a pair
// S_A2  | a_1 held, waiting for the second activation
// S_SET | pair held, counting down the neuron settle time
// S_OUT | result offered downstream; one next a_1 may be buffered (pend)
module neuron_o_feeder #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  neuron_o_feeder_if.slave  bus
);
  typedef enum logic [1:0] {S_A1, S_A2, S_SET, S_OUT} state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic                    r_pend;
  logic signed [WIDTH-1:0] r_a_1;
  logic signed [WIDTH-1:0] r_a_2;
  logic signed [WIDTH-1:0] r_out_data;
  logic                    r_out_valid;
  logic [CNT_W-1:0]        r_res_cnt;
  logic                    w_in_ready;
  logic                    w_in_fire;
  logic                    w_out_fire;

  // Ready, handshake strobes and next state; ready never looks at in_valid.
  always_comb begin
    w_in_ready = 1'b0;
    w_next     = r_state;
    case (r_state)
      S_A1:    w_in_ready = 1'b1;
      S_A2:    w_in_ready = 1'b1;
      S_SET:   w_in_ready = 1'b0;
      S_OUT:   w_in_ready = !r_pend;
      default: w_in_ready = 1'b0;
    endcase
    if (rst) w_in_ready = 1'b0;
    w_in_fire  = bus.in_valid && w_in_ready;
    w_out_fire = r_out_valid && bus.out_ready;
    case (r_state)
      S_A1:    if (w_in_fire) w_next = S_A2;
      S_A2:    if (w_in_fire) w_next = S_SET;
      S_SET:   if (r_cnt == 4'd0) w_next = S_OUT;
      S_OUT:   if (w_out_fire) w_next = (r_pend || w_in_fire) ? S_A2 : S_A1;
      default: w_next = S_A1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_A1;
    else     r_state <= w_next;
  end

  // Activation, settle counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_pend      <= 1'b0;
      r_a_1       <= '0;
      r_a_2       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_res_cnt   <= '0;
    end else begin
      case (r_state)
        S_A1: if (w_in_fire) r_a_1 <= bus.in_data;
        S_A2: begin
          if (w_in_fire) begin
            r_a_2 <= bus.in_data;
            r_cnt <= LP_SETTLE;
          end
        end
        S_SET: begin
          if (r_cnt == 4'd0) begin
            r_out_data  <= bus.y_in;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_OUT: begin
          // A buffered a_1 is safe to overwrite: the result is already registered.
          if (w_in_fire) begin
            r_a_1  <= bus.in_data;
            r_pend <= 1'b1;
          end
          // pend is consumed by moving to S_A2, so it clears even if set this edge.
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_res_cnt   <= r_res_cnt + CNT_W'(1);
            r_pend      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.a_1       = r_a_1;
  assign bus.a_2       = r_a_2;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.res_cnt   = r_res_cnt;
  assign bus.busy      = (r_state != S_A1) || r_pend;
endmodule

// File: tb/tb_neuron_o_feeder.sv
// Bench for neuron_o_feeder: three builds (SETTLE=1, SETTLE=0 with a 4-bit
// result counter, SETTLE=15), expected results queued per build and checked
// by independent output monitors.
module tb_neuron_o_feeder;
  logic clk;
  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  neuron_o_feeder_if #(.WIDTH(32), .CNT_W(16)) ia();
  neuron_o_feeder_if #(.WIDTH(32), .CNT_W(4))  ib();
  neuron_o_feeder_if #(.WIDTH(32), .CNT_W(16)) ic();

  neuron_o_feeder #(.WIDTH(32), .SETTLE(1),  .CNT_W(16)) u_a (.clk(clk), .rst(rst_a), .bus(ia));
  neuron_o_feeder #(.WIDTH(32), .SETTLE(0),  .CNT_W(4))  u_b (.clk(clk), .rst(rst_b), .bus(ib));
  neuron_o_feeder #(.WIDTH(32), .SETTLE(15), .CNT_W(16)) u_c (.clk(clk), .rst(rst_c), .bus(ic));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [31:0] data);
    case (d)
      0: begin ia.in_valid = v; ia.in_data = data; end
      1: begin ib.in_valid = v; ib.in_data = data; end
      default: begin ic.in_valid = v; ic.in_data = data; end
    endcase
  endtask

  task automatic set_y(input int d, input logic [31:0] y);
    case (d)
      0: ia.y_in = y;
      1: ib.y_in = y;
      default: ic.y_in = y;
    endcase
  endtask

  task automatic push_exp(input int d, input logic [31:0] v);
    case (d)
      0: qa.push_back(v);
      1: qb.push_back(v);
      default: qc.push_back(v);
    endcase
  endtask

  function automatic logic get_rdy(input int d);
    case (d)
      0: return ia.in_ready;
      1: return ib.in_ready;
      default: return ic.in_ready;
    endcase
  endfunction

  function automatic logic get_ov(input int d);
    case (d)
      0: return ia.out_valid;
      1: return ib.out_valid;
      default: return ic.out_valid;
    endcase
  endfunction

  // Offer one beat; returns at posedge+1 after the edge it transferred on.
  task automatic send_beat(input int d, input logic [31:0] data);
    logic fire;
    logic ok;
    ok = 1'b0;
    set_in(d, 1'b1, data);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      fire = get_rdy(d);
      @(posedge clk);
      #1;
      if (fire) begin
        ok = 1'b1;
        break;
      end
    end
    set_in(d, 1'b0, data);
    if (!ok) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  // Cycles from the current edge until out_valid is seen high (-1 on timeout).
  task automatic wait_out(input int d, output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (get_ov(d)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_pair(input int d, input logic [31:0] x1, input logic [31:0] x2,
                          input logic [31:0] y, input int exp_lat);
    int lat;
    set_y(d, y);
    push_exp(d, y);
    send_beat(d, x1);
    send_beat(d, x2);
    wait_out(d, lat);
    chk("latency", lat, exp_lat);
  endtask

  // Output monitors: every delivered result must match the head of its queue.
  always @(negedge clk) begin
    if (ia.out_valid && ia.out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_out act=%h req=none", ia.out_data);
      end else chk("a_out_data", ia.out_data, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ib.out_valid && ib.out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_out act=%h req=none", ib.out_data);
      end else chk("b_out_data", ib.out_data, qb.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ic.out_valid && ic.out_ready) begin
      if (qc.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_unexpected_out act=%h req=none", ic.out_data);
      end else chk("c_out_data", ic.out_data, qc.pop_front());
    end
  end

  initial begin
    int lat;
    int acc;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    set_in(0, 1'b0, 32'd0); set_in(1, 1'b0, 32'd0); set_in(2, 1'b0, 32'd0);
    set_y(0, 32'd0); set_y(1, 32'd0); set_y(2, 32'd0);
    ia.out_ready = 1'b0; ib.out_ready = 1'b0; ic.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ia.in_ready, 32'd0);
    chk("rst_a_1", ia.a_1, 32'd0);
    chk("rst_a_2", ia.a_2, 32'd0);
    chk("rst_out_valid", ia.out_valid, 32'd0);
    chk("rst_out_data", ia.out_data, 32'd0);
    chk("rst_res_cnt", ia.res_cnt, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;
    chk("idle_in_ready", ia.in_ready, 32'd1);
    chk("idle_busy", ia.busy, 32'd0);
    ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;

    // Basic pair, SETTLE=1.
    set_y(0, 32'h0000C000);
    push_exp(0, 32'h0000C000);
    send_beat(0, 32'h00010000);
    chk("basic_a_1", ia.a_1, 32'h00010000);
    send_beat(0, 32'hFFFF0000);
    chk("basic_a_2", ia.a_2, 32'hFFFF0000);
    chk("basic_busy", ia.busy, 32'd1);
    wait_out(0, lat);
    chk("basic_latency", lat, 32'd2);
    chk("basic_out_data", ia.out_data, 32'h0000C000);
    @(posedge clk); #1;
    chk("basic_res_cnt", ia.res_cnt, 32'd1);
    chk("basic_out_valid_low", ia.out_valid, 32'd0);

    // Backpressure: one beat buffered, further beats stall.
    ia.out_ready = 1'b0;
    run_pair(0, 32'h11, 32'h22, 32'h33, 2);
    acc = 0;
    set_in(0, 1'b1, 32'h44);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ia.in_valid && ia.in_ready) acc++;
      @(posedge clk); #1;
      if (acc > 0) ia.in_data = 32'h55;
    end
    chk("bp_accepted", acc, 32'd1);
    chk("bp_a_1", ia.a_1, 32'h44);
    chk("bp_in_ready", ia.in_ready, 32'd0);
    chk("bp_out_data", ia.out_data, 32'h33);
    chk("bp_out_valid", ia.out_valid, 32'd1);
    ia.out_ready = 1'b1;
    set_y(0, 32'h77);
    push_exp(0, 32'h77);
    send_beat(0, 32'h55);
    chk("bp_release_a_2", ia.a_2, 32'h55);
    chk("bp_release_a_1", ia.a_1, 32'h44);
    wait_out(0, lat);
    chk("bp_latency", lat, 32'd2);

    // Beat and result on the same edge.
    run_pair(0, 32'h101, 32'h202, 32'h303, 2);
    set_in(0, 1'b1, 32'h404);
    @(posedge clk); #1;
    set_in(0, 1'b0, 32'h404);
    chk("sim_res_cnt", ia.res_cnt, 32'd4);
    chk("sim_a_1", ia.a_1, 32'h404);
    chk("sim_out_valid", ia.out_valid, 32'd0);
    chk("sim_in_ready", ia.in_ready, 32'd1);
    chk("sim_busy", ia.busy, 32'd1);
    set_y(0, 32'h606);
    push_exp(0, 32'h606);
    send_beat(0, 32'h505);
    chk("sim_a_2", ia.a_2, 32'h505);
    wait_out(0, lat);
    chk("sim_latency", lat, 32'd2);
    @(posedge clk); #1;
    chk("sim_res_cnt2", ia.res_cnt, 32'd5);

    // Reset during S_SET.
    set_y(0, 32'hDEAD);
    send_beat(0, 32'h1);
    send_beat(0, 32'h2);
    rst_a = 1'b1;
    @(posedge clk); #1;
    chk("rset_in_ready", ia.in_ready, 32'd0);
    chk("rset_a_1", ia.a_1, 32'd0);
    chk("rset_a_2", ia.a_2, 32'd0);
    chk("rset_out_data", ia.out_data, 32'd0);
    chk("rset_res_cnt", ia.res_cnt, 32'd0);
    rst_a = 1'b0;
    #1;
    chk("rset_in_ready_rel", ia.in_ready, 32'd1);
    chk("rset_busy", ia.busy, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rset_no_out", ia.out_valid, 32'd0);

    // Reset in S_OUT with a buffered a_1.
    ia.out_ready = 1'b0;
    set_y(0, 32'hBEEF);
    send_beat(0, 32'h3);
    send_beat(0, 32'h4);
    wait_out(0, lat);
    chk("rout_latency", lat, 32'd2);
    send_beat(0, 32'h5);
    chk("rout_pend_in_ready", ia.in_ready, 32'd0);
    rst_a = 1'b1;
    @(posedge clk); #1;
    chk("rout_in_ready", ia.in_ready, 32'd0);
    chk("rout_a_1", ia.a_1, 32'd0);
    chk("rout_out_valid", ia.out_valid, 32'd0);
    chk("rout_out_data", ia.out_data, 32'd0);
    rst_a = 1'b0;
    ia.out_ready = 1'b1;
    #1;
    chk("rout_in_ready_rel", ia.in_ready, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("rout_no_out", ia.out_valid, 32'd0);
    run_pair(0, 32'h7, 32'h8, 32'h9, 2);
    @(posedge clk); #1;
    chk("rout_recover_cnt", ia.res_cnt, 32'd1);

    // SETTLE=0, 4-bit counter: 17 results wrap the count to 1.
    for (int k = 0; k < 17; k++)
      run_pair(1, 32'(k), 32'(k + 100), 32'h80000000 | 32'(k), 1);
    @(posedge clk); #1;
    chk("wrap_res_cnt", ib.res_cnt, 32'd1);

    // SETTLE=15: y_in toggles up to the sample edge, which is 16 edges on.
    set_y(2, 32'h5A5A0000);
    push_exp(2, 32'hFFFF8001);
    send_beat(2, 32'h12);
    send_beat(2, 32'h34);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      set_y(2, (k == 16) ? 32'hFFFF8001 : (32'h5A5A0000 | 32'(k)));
      @(posedge clk); #1;
      if (ic.out_valid) begin
        lat = k;
        break;
      end
    end
    set_y(2, 32'h13572468);
    chk("s15_latency", lat, 32'd16);
    chk("s15_out_data", ic.out_data, 32'hFFFF8001);
    @(posedge clk); #1;
    chk("s15_res_cnt", ic.res_cnt, 32'd1);

    repeat (3) @(posedge clk);
    chk("a_queue_empty", qa.size(), 32'd0);
    chk("b_queue_empty", qb.size(), 32'd0);
    chk("c_queue_empty", qc.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_o_feeder.md
Name: neuron_o_feeder

Overview:
- Sequential front/back end for the output neuron.
- Collects the two hidden-layer activations from a serial valid/ready stream and holds them stable on a_1/a_2 for the combinational output neuron.
- Waits a programmable settle time, registers the neuron result y, and offers it downstream on a valid/ready output.
- Allows the first activation of the next pair to be accepted while the current result is waiting.

Parameters:
- WIDTH, 32, signed data width of activations and result. Matches the neuron datapath.
- SETTLE, 1, extra cycles to wait after a_2 is registered before sampling y_in. Legal range 0..15.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream activation beat valid
- in_ready  output  1  block can accept an activation beat
- in_data  input  WIDTH  signed activation. First beat of a pair is a_1, second is a_2.
- a_1  output  WIDTH  registered activation 1, to neuron
- a_2  output  WIDTH  registered activation 2, to neuron
- y_in  input  WIDTH  signed combinational result from neuron
- out_valid  output  1  registered result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  registered result
- res_cnt  output  CNT_W  number of results delivered, wraps modulo 2^CNT_W
- busy  output  1  high in any state other than S_A1 with no pending a_1

Behaviour:
- One clock domain (clk). Reset rst is synchronous, active-high.
- Reset effects (rst high at a rising edge):
  - state goes to S_A1 and the cycle counter clears.
  - a_1, a_2, out_data, res_cnt go to 0; out_valid goes to 0.
  - The pend flag clears.
  - in_ready is forced to 0 while rst is high.
- Reset mid-operation discards any partial pair and any undelivered result. There is no output on the cycle after reset.

Handshake:
- A beat transfers on a rising edge with in_valid && in_ready.
- A result transfers on a rising edge with out_valid && out_ready.
- in_ready is combinational from state, pend and rst only. It never depends on in_valid.
- out_valid is a register. Once high, out_valid and out_data hold until the result transfers.

States:
- S_A1:
  - in_ready = 1.
  - On transfer: a_1 <= in_data; go to S_A2.
- S_A2:
  - in_ready = 1.
  - On transfer: a_2 <= in_data; cnt <= SETTLE; go to S_SET.
- S_SET:
  - in_ready = 0.
  - If cnt == 0: out_data <= y_in, out_valid <= 1, go to S_OUT.
  - Otherwise cnt <= cnt - 1.
  - Latency from the a_2 transfer edge to out_valid high is SETTLE+1 cycles.
  - a_1 and a_2 are stable for the whole of S_SET.
- S_OUT:
  - in_ready = !pend.
  - Beat transfer: a_1 <= in_data, pend <= 1. out_data is unaffected because it is registered.
  - Result transfer: out_valid <= 0, res_cnt <= res_cnt + 1, pend <= 0.
  - Next state on result transfer: S_A2 if pend was set (or is being set this edge), else S_A1.
  - A beat and a result transferring on the same edge: both take effect and the next state is S_A2.
  - Without a result transfer, the block stays in S_OUT.

Arithmetic and width rules:
- No arithmetic on data. Values pass through bit-exact; signedness is preserved.
- res_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- cnt is 4 bits. SETTLE above 15 is illegal and is not checked.

Boundary conditions:
- in_valid held high continuously: pairs stream in with at most one a_1 buffered ahead.
- out_ready held low: a second beat stalls with in_ready = 0; nothing is dropped.
- y_in is sampled only in S_SET at cnt == 0. Changes on y_in at any other time are ignored.

Test Plan:
- Reset then basic pair, SETTLE=1:
  - Stimulus: in_data 0x00010000 then 0xFFFF0000; bench drives y_in = 0x0000C000; out_ready = 1.
  - Required: a_1/a_2 show those values; out_valid rises 2 cycles after the a_2 edge; out_data = 0x0000C000; res_cnt = 1.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles after out_valid; offer 3 beats.
  - Required: exactly 1 beat is accepted (a_1 updated, pend set) and in_ready then stays 0; out_data is unchanged; on release, state goes to S_A2 and the next beat loads a_2.
- Simultaneous events:
  - Stimulus: in S_OUT with pend = 0, in_valid = out_ready = 1 on the same edge.
  - Required: res_cnt increments, a_1 loads, next state is S_A2, out_valid = 0.
- SETTLE=0 and SETTLE=15 builds:
  - Required latency from the a_2 edge to out_valid is 1 and 16 cycles respectively.
  - Toggling y_in before the sample cycle does not affect out_data.
- Reset mid-operation:
  - Stimulus: assert rst in S_SET and in S_OUT with pend = 1.
  - Required: next cycle all outputs are 0, in_ready = 0 while rst is high, then 1 in S_A1; no spurious result.
- Counter wrap:
  - Stimulus: CNT_W = 4; deliver 17 results.
  - Required: res_cnt = 1.
